aes_decrypt_ctrl: RTL and testbench

AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_dec_final_round.sv | 25 ++
 rtl/aes_inv_ops.sv | 51 +++++
 rtl/aes_decrypt_ctrl.sv | 109 ++++++++++
 tb/tb_aes_decrypt_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES decrypt types: FSM states, block type, GF(2^8) helpers.
// Optional abort feature of aes_decrypt_ctrl is enabled by AES_DEC_ABORT_EN.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } dec_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse affine map, then multiplicative inverse as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] r;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        s = b;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_dec_final_round.sv
// Combinational last inverse round: InvSubBytes, InvShiftRows, AddRoundKey.
module aes_dec_final_round import aes_pkg::*; (
    input  block_t data,
    input  block_t key,
    output block_t result
);
    block_t sub_out;
    block_t shr_out;

    InvSubBytes u_isb (
        .data   (data),
        .result (sub_out)
    );

    InvShiftRows u_isr (
        .data   (sub_out),
        .result (shr_out)
    );

    AddRoundKey u_ark (
        .data   (shr_out),
        .key    (key),
        .result (result)
    );
endmodule

// File: rtl/aes_inv_ops.sv
// AES inverse-cipher primitives: InvSubBytes, InvShiftRows, AddRoundKey, Inv_MixColumns.
// Byte i of a block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
module InvSubBytes import aes_pkg::*; (
    input  logic [127:0] data,
    output logic [127:0] result
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign result[8*i +: 8] = inv_sbox(data[8*i +: 8]);
    end
endmodule

module InvShiftRows (
    input  logic [127:0] data,
    output logic [127:0] result
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign result[127-8*(r+4*c) -: 8] =
                data[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end
endmodule

module AddRoundKey (
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = data ^ key;
endmodule

module Inv_MixColumns import aes_pkg::*; (
    input  logic [127:0] data,
    output logic [127:0] result
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data[127-32*c -: 8];
        assign a1 = data[119-32*c -: 8];
        assign a2 = data[111-32*c -: 8];
        assign a3 = data[103-32*c -: 8];
        assign result[127-32*c -: 8] =
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign result[119-32*c -: 8] =
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign result[111-32*c -: 8] =
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign result[103-32*c -: 8] =
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES decrypt sequencer, one inverse round per clock, external key store.
// Define AES_DEC_ABORT_EN to add the abort input.
module aes_decrypt_ctrl import aes_pkg::*; #(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic                abort
`endif
);

    dec_state_t          fsm, fsm_nxt;
    block_t              state_reg, blk_nxt;
    logic [RK_IDX_W-1:0] round_cnt, cnt_nxt;
    block_t              fin_out, rnd_out;

    // A full round is the final-round path followed by InvMixColumns.
    aes_dec_final_round u_fin (
        .data   (state_reg),
        .key    (rk_data),
        .result (fin_out)
    );

    Inv_MixColumns u_imc (
        .data   (fin_out),
        .result (rnd_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_reg <= '0;
            round_cnt <= '0;
        end else begin
            fsm       <= fsm_nxt;
            state_reg <= blk_nxt;
            round_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        blk_nxt   = state_reg;
        cnt_nxt   = round_cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = '0;
        unique case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    blk_nxt = in_data;
                    fsm_nxt = INIT;
                end
            end
            INIT: begin
                rk_idx  = RK_IDX_W'(NR);
                blk_nxt = state_reg ^ rk_data;
                cnt_nxt = RK_IDX_W'(NR - 1);
                fsm_nxt = ROUND;
            end
            ROUND: begin
                rk_idx  = round_cnt;
                blk_nxt = rnd_out;
                if (round_cnt == RK_IDX_W'(1)) begin
                    fsm_nxt = FINAL;
                end else begin
                    cnt_nxt = round_cnt - RK_IDX_W'(1);
                end
            end
            FINAL: begin
                blk_nxt = fin_out;
                fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase
`ifdef AES_DEC_ABORT_EN
        // Abort wins over everything, including a DONE handshake.
        if (abort && fsm != IDLE) begin
            fsm_nxt = IDLE;
            blk_nxt = state_reg;
            cnt_nxt = '0;
        end
`endif
    end

    assign out_data = state_reg;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Scoreboard bench for aes_decrypt_ctrl: a forward AES-128 model encrypts random
// plaintexts; the monitor checks the decrypted result, timing and handshakes.
module tb_aes_decrypt_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk_mem [0:10];
    logic [7:0]   sbox [0:255];
    logic [127:0] sb [$];

    int errors = 0;
    int checks = 0;
    bit tmo = 1'b0;
    bit fin = 1'b0;

    always #5 clk = ~clk;

    assign rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

    aes_decrypt_ctrl #(.NR(NR), .RK_IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_DEC_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: field inverse by search, then affine map.
    task automatic build_sbox();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            sbox[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                        ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        logic [127:0] k;
        blk = pt ^ rk_mem[0];
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            k = rk_mem[rnd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
        return blk;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int           cyc = 0;
    int           acc_cyc = 0;
    int           hs_cyc = -10;
    int           acc_n = 0;
    int           hs_n = 0;
    int           k;
    bit           inflight = 1'b0;
    bit           stall_prev = 1'b0;
    bit           ab_pend = 1'b0;
    bit           tmo_seen = 1'b0;
    bit           fin_seen = 1'b0;
    logic [127:0] prev_data = '0;
    logic [127:0] exp_pt;

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk(in_ready === 1'b1 && out_valid === 1'b0 && busy === 1'b0
                && rk_idx === 4'd0, "reset_outputs",
                {in_ready, out_valid, busy, rk_idx}, 128'h40);
            inflight   = 1'b0;
            stall_prev = 1'b0;
            ab_pend    = 1'b0;
            acc_n      = hs_n;
        end else begin
            if (ab_pend) begin
                chk(in_ready && !out_valid && !busy, "abort_to_idle",
                    {in_ready, out_valid, busy}, 128'h4);
                ab_pend = 1'b0;
            end
            if (inflight) begin
                k = cyc - acc_cyc;
                if (out_valid) begin
                    chk(k - 1 == NR + 1, "latency", k - 1, NR + 1);
                    inflight = 1'b0;
                end else if (k <= NR + 1) begin
                    chk(rk_idx == 4'(NR + 1 - k) && busy && !in_ready,
                        "rk_idx_trace", rk_idx, NR + 1 - k);
                end else begin
                    chk(1'b0, "latency_missing", k, NR + 2);
                    inflight = 1'b0;
                end
            end
            if (in_ready)
                chk(rk_idx == 4'd0 && !busy && !out_valid, "idle_outputs",
                    {rk_idx, busy, out_valid}, 128'h0);
            if (stall_prev)
                chk(out_valid && out_data == prev_data && !in_ready && busy,
                    "stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", out_data, 128'h0);
                end else begin
                    exp_pt = sb.pop_front();
                    chk(out_data == exp_pt, "plaintext", out_data, exp_pt);
                end
                hs_n++;
                hs_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && cyc == hs_cyc + 1)
                chk(in_ready, "idle_gap_accept", in_ready, 128'h1);
            if (in_valid && in_ready) begin
                chk(acc_n == hs_n, "one_accept_per_done", acc_n, hs_n);
                acc_n++;
                inflight = 1'b1;
                acc_cyc  = cyc;
            end
`ifdef AES_DEC_ABORT_EN
            if (abort && busy) begin
                ab_pend    = 1'b1;
                inflight   = 1'b0;
                stall_prev = 1'b0;
                acc_n      = hs_n;
            end
`endif
        end
        if (tmo && !tmo_seen) begin
            chk(1'b0, "wait_bound", 128'h0, 128'h1);
            tmo_seen = 1'b1;
        end
        if (fin && !fin_seen) begin
            chk(sb.size() == 0, "scoreboard_drained", sb.size(), 128'h0);
            fin_seen = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] ct);
        int n;
        n = 0;
        in_data  = ct;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready && rst_n) break;
            n++;
            if (n > 300) begin
                tmo = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_send(input logic [127:0] pt);
        sb.push_back(pt);
        send(encrypt(pt));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 || !in_ready) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                tmo = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rk(input logic [3:0] v);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (busy && rk_idx == v) break;
            n++;
            if (n > 100) begin
                tmo = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef AES_DEC_ABORT_EN
        abort     = 1'b0;
`endif
        build_sbox();
        expand(128'h000102030405060708090a0b0c0d0e0f);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer vector
        sb.push_back(128'h00112233445566778899aabbccddeeff);
        send(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        in_valid = 1'b0;
        wait_drain();

        // Random blocks with random idle gaps
        for (int i = 0; i < 4; i++) begin
            push_send(rand128());
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();

        // New key, in_valid held high back to back
        expand(rand128());
        for (int i = 0; i < 5; i++) push_send(rand128());
        in_valid = 1'b0;
        wait_drain();

        // Consumer stall while DONE
        out_ready = 1'b0;
        push_send(rand128());
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) tmo = 1'b1;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of the rounds discards the block
        send(rand128());
        in_valid = 1'b0;
        wait_rk(4'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_send(rand128());
        in_valid = 1'b0;
        wait_drain();

`ifdef AES_DEC_ABORT_EN
        send(rand128());
        in_valid = 1'b0;
        wait_rk(4'd5);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        push_send(rand128());
        in_valid = 1'b0;
        wait_drain();
`endif

        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
